enc_8b10b_tx_mopshub: RTL and testbench
=======================================

Name: enc_8b10b_tx_mopshub

Overview:
- 8b/10b transmit encoder for the MOPS-Hub serial link; feeds the serializer with 10-bit symbols, one per symbol strobe.
- Owns running disparity (RD), accepts bytes through a valid/ready handshake and inserts idle commas when no data is offered.
- Emits a comma sync preamble after reset.
- Output bit order matches the hub's 8b/10b decoder: dataout[9]=a … dataout[0]=j.

Parameters:
- SYNC_COMMAS, 4, number of idle symbols sent after reset before din_ready can assert (1..255).
- IDLE_CHAR, 8'hBC, K-code used for idle and sync symbols (default K28.5); must be a valid K-code.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous and active-low.
- sym_en  in  1  symbol strobe from the serializer; one symbol is produced per cycle with sym_en=1.
- din  in  8  byte to encode, as {H,G,F,E,D,C,B,A}.
- din_k  in  1  din is a control (K) character.
- din_valid  in  1  din/din_k valid.
- din_ready  out  1  byte accepted this cycle when din_valid & din_ready.
- dataout  out  10  encoded symbol {a,b,c,d,e,i,f,g,h,j}, registered.
- dataout_valid  out  1  one-cycle pulse; dataout was updated this cycle.
- rd_out  out  1  current RD after the last emitted symbol (0=RD-, 1=RD+).
- k_err  out  1  one-cycle pulse; an invalid K-code was accepted and replaced by IDLE_CHAR.
- sync_done  out  1  high once the sync preamble has completed.

Behaviour:
- Reset (rst=0, asynchronous):
  - dataout = 10'b0011111010 (K28.5, RD-).
  - dataout_valid = 0, rd_out = 0, k_err = 0, sync_done = 0, din_ready = 0.
  - sync counter = 0, FSM = SYNC.
- Assertion mid-symbol discards the pending byte; no partial symbol is ever output.
- FSM:
  - SYNC: each sym_en emits IDLE_CHAR and increments the counter. When counter reaches SYNC_COMMAS-1 on sym_en, go to RUN; sync_done goes high in the same edge.
  - RUN: stays in RUN until reset.
- Handshake:
  - din_ready = (FSM==RUN) & sym_en, combinational.
  - A transfer occurs when din_valid & din_ready.
  - din_valid without sym_en waits; the byte must be held stable by the source.
- Per sym_en cycle in RUN:
  - Transfer: encode din/din_k.
  - No transfer: encode IDLE_CHAR as K.
  - Result registers on the same clk edge; dataout_valid is 1 for the following cycle only. Latency is 1 cycle from the sym_en edge to dataout.
- sym_en=0: dataout and rd_out hold, dataout_valid=0.
- Encoding: standard Widmer–Franaszek 5b/6b and 3b/4b tables.
  - 6b sub-block is selected by the RD at symbol start; 4b sub-block is selected by the RD after the 6b sub-block.
  - Neutral sub-blocks keep RD. Unbalanced sub-blocks flip RD; their polarity always drives RD back toward balance.
  - D.x.7 uses the alternate A7 code (0111 at RD-, 1000 at RD+) for x = 17, 18, 20 at RD- and x = 11, 13, 14 at RD+.
  - K28.y uses the K 3b/4b alternates, giving the complementary pairs.
- Valid K-codes: K28.0–K28.7, K23.7, K27.7, K29.7, K30.7. Any other din with din_k=1 is encoded as IDLE_CHAR and pulses k_err together with dataout_valid.
- rd_out is updated only when a symbol is emitted. Every emitted symbol must have disparity 0 or ±2, and the running sum never leaves ±1.
- Back-to-back transfers on consecutive sym_en cycles are supported at full rate with no bubbles.

Test Plan:
- Reset release, sym_en=1 every cycle, din_valid=1 → first 4 dataout are 0011111010, 1100000101, 0011111010, 1100000101. din_ready=0 throughout; sync_done rises with the 4th symbol; din_ready=1 on the 5th cycle.
- RUN at RD-: send D21.5 (din=8'hB5, din_k=0) → 1010101010, rd_out stays 0. Then D0.0 (8'h00) → 1001110100, rd_out 0.
- RD- with D17.7 (8'hF1) → 1000110111 (A7 path). Force RD+ with K28.5, then D11.7 (8'hEB) → 1101001000 (A7 at RD+).
- din_k=1, din=8'h00 (invalid K) → IDLE_CHAR encoded at the current RD, k_err pulses for one cycle, and RD is updated as for K28.5.
- din_valid=0 for 3 sym_en cycles in RUN → alternating K28.5 symbols, dataout_valid pulses 3 times. Then sym_en held 0 for 5 cycles → dataout holds, dataout_valid=0, din_ready=0.
- rst asserted asynchronously between clock edges mid-stream → outputs take reset values immediately; after release, the sync preamble repeats from count 0 starting at RD-.

Source files
------------

// File: rtl/enc_8b10b_tx_mopshub.sv
// 8b/10b transmit encoder for the MOPS-Hub serial link: comma sync preamble,
// valid/ready byte intake, idle comma fill and running-disparity tracking.
module enc_8b10b_tx_mopshub #(
   parameter int unsigned SYNC_COMMAS = 4,
   parameter logic [7:0]  IDLE_CHAR   = 8'hBC
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sym_en,
   input  logic [7:0] din,
   input  logic       din_k,
   input  logic       din_valid,
   output logic       din_ready,
   output logic [9:0] dataout,
   output logic       dataout_valid,
   output logic       rd_out,
   output logic       k_err,
   output logic       sync_done
);

   typedef enum logic {SYNC, RUN} state_t;

   typedef struct packed {
      logic [7:0] data;
      logic       k;
      logic       bad;
   } char_t;

   localparam logic [7:0] LAST_SYNC = 8'(SYNC_COMMAS - 1);

   state_t      state;
   logic [7:0]  sync_cnt;
   logic        xfer;
   logic        k_ok;
   char_t       ch;
   logic [10:0] enc;

   // Returns {rd_after, abcdei, fghj}; tables hold the RD- column.
   function automatic logic [10:0] encode(input logic [7:0] b, input logic k, input logic rd);
      logic [4:0] x;
      logic [2:0] y;
      logic [5:0] c6;
      logic [3:0] c4;
      logic       rd6;
      logic       a7;
      x = b[4:0];
      y = b[7:5];
      case (x)
         5'd0:    c6 = 6'b100111;
         5'd1:    c6 = 6'b011101;
         5'd2:    c6 = 6'b101101;
         5'd3:    c6 = 6'b110001;
         5'd4:    c6 = 6'b110101;
         5'd5:    c6 = 6'b101001;
         5'd6:    c6 = 6'b011001;
         5'd7:    c6 = 6'b111000;
         5'd8:    c6 = 6'b111001;
         5'd9:    c6 = 6'b100101;
         5'd10:   c6 = 6'b010101;
         5'd11:   c6 = 6'b110100;
         5'd12:   c6 = 6'b001101;
         5'd13:   c6 = 6'b101100;
         5'd14:   c6 = 6'b011100;
         5'd15:   c6 = 6'b010111;
         5'd16:   c6 = 6'b011011;
         5'd17:   c6 = 6'b100011;
         5'd18:   c6 = 6'b010011;
         5'd19:   c6 = 6'b110010;
         5'd20:   c6 = 6'b001011;
         5'd21:   c6 = 6'b101010;
         5'd22:   c6 = 6'b011010;
         5'd23:   c6 = 6'b111010;
         5'd24:   c6 = 6'b110011;
         5'd25:   c6 = 6'b100110;
         5'd26:   c6 = 6'b010110;
         5'd27:   c6 = 6'b110110;
         5'd28:   c6 = 6'b001110;
         5'd29:   c6 = 6'b101110;
         5'd30:   c6 = 6'b011110;
         default: c6 = 6'b101011;
      endcase
      if (k && x == 5'd28) c6 = 6'b001111;
      // D.07 is balanced but still has an RD+ form
      if (rd && ($countones(c6) != 3 || x == 5'd7)) c6 = ~c6;
      rd6 = rd ^ ($countones(c6) != 3);
      a7  = (y == 3'd7) && (rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                                : (x == 5'd17 || x == 5'd18 || x == 5'd20));
      if (k) begin
         case (y)
            3'd0:    c4 = 4'b1011;
            3'd1:    c4 = 4'b0110;
            3'd2:    c4 = 4'b1010;
            3'd3:    c4 = 4'b1100;
            3'd4:    c4 = 4'b1101;
            3'd5:    c4 = 4'b0101;
            3'd6:    c4 = 4'b1001;
            default: c4 = 4'b0111;
         endcase
         if (rd6) c4 = ~c4;
      end else begin
         case (y)
            3'd0:    c4 = 4'b1011;
            3'd1:    c4 = 4'b1001;
            3'd2:    c4 = 4'b0101;
            3'd3:    c4 = 4'b1100;
            3'd4:    c4 = 4'b1101;
            3'd5:    c4 = 4'b1010;
            3'd6:    c4 = 4'b0110;
            default: c4 = 4'b1110;
         endcase
         if (a7) c4 = 4'b0111;
         if (rd6 && ($countones(c4) != 2 || y == 3'd3)) c4 = ~c4;
      end
      return {rd6 ^ ($countones(c4) != 2), c6, c4};
   endfunction

   assign din_ready = (state == RUN) & sym_en;
   assign xfer      = din_valid & din_ready;
   assign k_ok      = (din[4:0] == 5'd28) ||
                      (din[7:5] == 3'd7 && (din[4:0] == 5'd23 || din[4:0] == 5'd27 ||
                                            din[4:0] == 5'd29 || din[4:0] == 5'd30));

   always_comb begin
      ch = '{data: IDLE_CHAR, k: 1'b1, bad: 1'b0};
      if (xfer) begin
         if (din_k && !k_ok) begin
            ch.bad = 1'b1;
         end else begin
            ch.data = din;
            ch.k    = din_k;
         end
      end
   end

   assign enc = encode(ch.data, ch.k, rd_out);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= SYNC;
         sync_cnt      <= '0;
         dataout       <= 10'b0011111010;
         dataout_valid <= 1'b0;
         rd_out        <= 1'b0;
         k_err         <= 1'b0;
         sync_done     <= 1'b0;
      end else begin
         dataout_valid <= 1'b0;
         k_err         <= 1'b0;
         if (sym_en) begin
            dataout       <= enc[9:0];
            rd_out        <= enc[10];
            dataout_valid <= 1'b1;
            k_err         <= ch.bad;
            if (state == SYNC) begin
               if (sync_cnt == LAST_SYNC) begin
                  state     <= RUN;
                  sync_done <= 1'b1;
               end else begin
                  sync_cnt <= sync_cnt + 8'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_enc_8b10b_tx_mopshub.sv
// Randomized bench for enc_8b10b_tx_mopshub against a table-driven 8b/10b model
// using explicit RD-/RD+ code columns and whole-symbol disparity.
module tb_enc_8b10b_tx_mopshub;

   localparam int SC = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       sym_en;
   logic [7:0] din;
   logic       din_k;
   logic       din_valid;
   logic       din_ready;
   logic [9:0] dataout;
   logic       dataout_valid;
   logic       rd_out;
   logic       k_err;
   logic       sync_done;

   enc_8b10b_tx_mopshub #(.SYNC_COMMAS(SC), .IDLE_CHAR(8'hBC)) dut (
      .clk(clk), .rst(rst), .sym_en(sym_en), .din(din), .din_k(din_k),
      .din_valid(din_valid), .din_ready(din_ready), .dataout(dataout),
      .dataout_valid(dataout_valid), .rd_out(rd_out), .k_err(k_err),
      .sync_done(sync_done)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] M6 [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
   localparam logic [5:0] P6 [32] = '{
      6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
      6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
      6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
      6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
   localparam logic [3:0] D4M [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
   localparam logic [3:0] D4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
   localparam logic [3:0] K4M [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
   localparam logic [3:0] K4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
   localparam logic [7:0] KLIST [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                        8'hF7, 8'hFB, 8'hFD, 8'hFE};
   localparam logic [9:0] SYNC_SYM [4] = '{10'b0011111010, 10'b1100000101, 10'b0011111010, 10'b1100000101};

   int n_chk = 0;
   int n_err = 0;

   // model state
   logic       m_rd, m_run;
   int         m_cnt;
   logic [9:0] e_dout;
   logic       e_dv, e_kerr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic valid_k(input logic [7:0] b);
      int x;
      x = int'(b[4:0]);
      return (x == 28) || (b[7:5] == 3'd7 && (x == 23 || x == 27 || x == 29 || x == 30));
   endfunction

   // returns {rd_after, symbol}
   function automatic logic [10:0] ref_sym(input logic [7:0] b, input logic k, input logic rd);
      int         x, y, n6, n;
      logic [5:0] c6;
      logic [3:0] c4;
      logic       rd6, rdn;
      x = int'(b[4:0]);
      y = int'(b[7:5]);
      if (k && x == 28) c6 = rd ? 6'b110000 : 6'b001111;
      else              c6 = rd ? P6[x] : M6[x];
      n6  = $countones(c6);
      rd6 = (n6 == 4) ? 1'b1 : (n6 == 2) ? 1'b0 : rd;
      if (k)
         c4 = rd6 ? K4P[y] : K4M[y];
      else if (y == 7 && ((!rd6 && (x == 17 || x == 18 || x == 20)) ||
                          ( rd6 && (x == 11 || x == 13 || x == 14))))
         c4 = rd6 ? 4'b1000 : 4'b0111;
      else
         c4 = rd6 ? D4P[y] : D4M[y];
      n   = $countones({c6, c4});
      rdn = (n == 6) ? 1'b1 : (n == 4) ? 1'b0 : rd;
      return {rdn, c6, c4};
   endfunction

   task automatic model_reset();
      m_rd = 1'b0; m_run = 1'b0; m_cnt = 0;
      e_dout = 10'b0011111010; e_dv = 1'b0; e_kerr = 1'b0;
   endtask

   // One clock: drive, check ready, clock, advance model, check outputs.
   task automatic cyc(input logic se, input logic dv, input logic [7:0] d, input logic k);
      logic        exp_rdy, rd0, ck;
      logic [7:0]  cb;
      logic        bad;
      logic [10:0] r;
      int          n;
      sym_en = se; din_valid = dv; din = d; din_k = k;
      #1;
      exp_rdy = m_run & se;
      chk("din_ready", din_ready, exp_rdy);
      @(posedge clk);
      rd0 = m_rd;
      if (se) begin
         cb = 8'hBC; ck = 1'b1; bad = 1'b0;
         if (exp_rdy && dv) begin
            if (k && !valid_k(d)) bad = 1'b1;
            else begin cb = d; ck = k; end
         end
         r      = ref_sym(cb, ck, m_rd);
         e_dout = r[9:0];
         m_rd   = r[10];
         e_dv   = 1'b1;
         e_kerr = bad;
         if (!m_run) begin
            if (m_cnt == SC - 1) m_run = 1'b1;
            else m_cnt++;
         end
      end else begin
         e_dv = 1'b0; e_kerr = 1'b0;
      end
      #1;
      chk("dataout", dataout, e_dout);
      chk("dataout_valid", dataout_valid, e_dv);
      chk("rd_out", rd_out, m_rd);
      chk("k_err", k_err, e_kerr);
      chk("sync_done", sync_done, m_run);
      if (se) begin
         n = $countones(dataout);
         chk("disparity", (n >= 4 && n <= 6 && (rd0 ? n <= 5 : n >= 5)), 1);
      end
   endtask

   task automatic sync_pre();
      for (int i = 0; i < SC; i++) begin
         cyc(1'b1, 1'b1, 8'hB5, 1'b0);
         chk("sync_sym", dataout, SYNC_SYM[i]);
         chk("sync_done_edge", sync_done, (i == SC - 1));
      end
   endtask

   task automatic rand_phase(input int ncyc);
      logic       h_dv, h_k, se, xf;
      logic [7:0] h_d;
      int         r;
      h_dv = 1'b0; h_k = 1'b0; h_d = 8'h00;
      for (int i = 0; i < ncyc; i++) begin
         se = ($urandom_range(0, 3) != 0);
         if (!h_dv) begin
            h_dv = ($urandom_range(0, 3) != 0);
            r    = $urandom_range(0, 9);
            if (r < 6)      begin h_d = 8'($urandom); h_k = 1'b0; end
            else if (r < 8) begin h_d = KLIST[$urandom_range(0, 11)]; h_k = 1'b1; end
            else            begin h_d = 8'($urandom); h_k = 1'b1; end
         end
         xf = se & m_run & h_dv;
         cyc(se, h_dv, h_d, h_k);
         if (xf) h_dv = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b0; sym_en = 1'b0; din = 8'h00; din_k = 1'b0; din_valid = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dataout", dataout, 10'b0011111010);
      chk("rst_dv", dataout_valid, 0);
      chk("rst_rd", rd_out, 0);
      chk("rst_kerr", k_err, 0);
      chk("rst_sync", sync_done, 0);
      chk("rst_ready", din_ready, 0);
      @(negedge clk);
      rst = 1'b1;

      sync_pre();
      cyc(1'b1, 1'b1, 8'hB5, 1'b0);
      chk("d21_5", dataout, 10'b1010101010);
      chk("d21_5_rd", rd_out, 0);
      cyc(1'b1, 1'b1, 8'h00, 1'b0);
      chk("d0_0", dataout, 10'b1001110100);
      chk("d0_0_rd", rd_out, 0);
      cyc(1'b1, 1'b1, 8'hF1, 1'b0);
      chk("d17_7_a7", dataout, 10'b1000110111);
      chk("d17_7_rd", rd_out, 1);
      cyc(1'b1, 1'b1, 8'hBC, 1'b1);
      chk("k28_5_rdp", dataout, 10'b1100000101);
      cyc(1'b1, 1'b1, 8'hBC, 1'b1);
      chk("k28_5_rdm", dataout, 10'b0011111010);
      chk("k28_5_rd", rd_out, 1);
      cyc(1'b1, 1'b1, 8'hEB, 1'b0);
      chk("d11_7_a7", dataout, 10'b1101001000);
      chk("d11_7_rd", rd_out, 0);
      cyc(1'b1, 1'b1, 8'h00, 1'b1);
      chk("badk_sym", dataout, 10'b0011111010);
      chk("badk_err", k_err, 1);
      chk("badk_rd", rd_out, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 8'h55, 1'b0);
         chk("idle_sym", dataout, SYNC_SYM[(i + 1) % 2]);
      end
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b1, 8'h55, 1'b0);
         chk("hold_sym", dataout, 10'b1100000101);
      end

      rand_phase(500);

      // asynchronous reset between edges
      sym_en = 1'b1; din_valid = 1'b1;
      #3 rst = 1'b0;
      #1;
      chk("arst_dataout", dataout, 10'b0011111010);
      chk("arst_dv", dataout_valid, 0);
      chk("arst_rd", rd_out, 0);
      chk("arst_kerr", k_err, 0);
      chk("arst_sync", sync_done, 0);
      chk("arst_ready", din_ready, 0);
      model_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      sync_pre();
      rand_phase(500);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
